// File: rtl/seg_scan_controller.sv
// Four-digit active-low seven-segment scan controller with frame handshake, blink and guard cycle.
// Outputs are registered (first lit cycle 2 cycles after a slot tick); a held frame is released only on a scan wrap.
module seg_scan_controller #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD,
   input  logic [19:0] LETTERS,
   input  logic [3:0]  BLINK_EN,
   output logic        READY,
   output logic [4:0]  LET,
   input  logic [7:0]  SEG_IN,
   output logic [7:0]  seg,
   output logic [3:0]  an
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [0:0] GUARD = 1'b0;
   localparam logic [0:0] DRIVE = 1'b1;

   logic [CW-1:0] prescale;
   logic [1:0]    idx;
   logic [19:0]   display;
   logic [19:0]   pending;
   logic [FW-1:0] frame_cnt;
   logic          blink_off;
   logic [0:0]    state;
   logic [0:0]    next_state;
   logic          tick;
   logic          wrap;
   logic [4:0]    cur;
   logic          dark;

   assign tick = (prescale == CW'(REFRESH_DIV - 1));
   assign wrap = tick && (idx == 2'd3);

   always_comb begin
      cur = display[4:0];
      case (idx)
         2'd1:    cur = display[9:5];
         2'd2:    cur = display[14:10];
         2'd3:    cur = display[19:15];
         default: cur = display[4:0];
      endcase
   end

   assign LET  = cur;
   assign dark = (cur >= 5'd26) || (blink_off && BLINK_EN[idx]);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prescale <= '0;
         idx      <= 2'd0;
      end else if (tick) begin
         prescale <= '0;
         idx      <= idx + 2'd1;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   // A frame accepted on a wrap edge has READY high there, so it is held for the next wrap.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         READY   <= 1'b1;
         pending <= '1;
         display <= '1;
      end else if (wrap && !READY) begin
         display <= pending;
         READY   <= 1'b1;
      end else if (LOAD && READY) begin
         pending <= LETTERS;
         READY   <= 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         frame_cnt <= '0;
         blink_off <= 1'b0;
      end else if (wrap) begin
         if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            blink_off <= ~blink_off;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         GUARD:   next_state = DRIVE;
         DRIVE:   if (tick) next_state = GUARD;
         default: next_state = GUARD;
      endcase
   end

   // Outputs follow the next state so the guard cycle blanks the pins while idx settles.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= GUARD;
         an    <= 4'hF;
         seg   <= 8'hFF;
      end else begin
         state <= next_state;
         if (next_state == GUARD) begin
            an  <= 4'hF;
            seg <= 8'hFF;
         end else begin
            an  <= ~(4'b0001 << idx);
            seg <= dark ? 8'hFF : SEG_IN;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized bench for seg_scan_controller against a cycle-count based reference model.
module tb_seg_scan_controller;

   localparam int DIV  = 4;
   localparam int BF   = 2;
   localparam int SCAN = 4 * DIV;

   logic        CLK;
   logic        RST;
   logic        LOAD;
   logic [19:0] LETTERS;
   logic [3:0]  BLINK_EN;
   logic        READY;
   logic [4:0]  LET;
   logic [7:0]  SEG_IN;
   logic [7:0]  seg;
   logic [3:0]  an;

   int checks = 0;
   int errors = 0;

   seg_scan_controller #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
      .CLK(CLK), .RST(RST), .LOAD(LOAD), .LETTERS(LETTERS), .BLINK_EN(BLINK_EN),
      .READY(READY), .LET(LET), .SEG_IN(SEG_IN), .seg(seg), .an(an)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // External decoder: blank codes decode to all-on so any leak through is visible.
   function automatic logic [7:0] dec(input logic [4:0] c);
      case (c)
         5'd0: return 8'h11;
         5'd1: return 8'hC1;
         5'd2: return 8'h63;
         5'd3: return 8'h85;
         default: return (c < 5'd26) ? ({c, 3'b010} ^ 8'h24) : 8'h00;
      endcase
   endfunction

   assign SEG_IN = dec(LET);

   // Reference model: time is counted in cycles since reset; slot, digit and frame follow by division.
   int          m_cyc;
   logic        m_ready;
   logic [19:0] m_pend;
   logic [19:0] m_disp;
   logic [3:0]  be_prev;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_cyc   <= 0;
         m_ready <= 1'b1;
         m_pend  <= 20'hFFFFF;
         m_disp  <= 20'hFFFFF;
         be_prev <= 4'h0;
      end else begin
         if ((m_cyc % SCAN) == SCAN - 1 && !m_ready) begin
            m_disp  <= m_pend;
            m_ready <= 1'b1;
         end else if (LOAD && m_ready) begin
            m_pend  <= LETTERS;
            m_ready <= 1'b0;
         end
         m_cyc   <= m_cyc + 1;
         be_prev <= BLINK_EN;
      end
   end

   function automatic int cur_digit();
      return (m_cyc / DIV) % 4;
   endfunction

   function automatic logic [4:0] exp_let();
      return m_disp[cur_digit()*5 +: 5];
   endfunction

   function automatic logic [3:0] exp_an();
      logic [3:0] one;
      one = 4'b0001;
      if (m_cyc % DIV == 0) return 4'hF;
      return ~(one << cur_digit());
   endfunction

   function automatic logic [7:0] exp_seg();
      logic [4:0] code;
      bit         off;
      int         d;
      if (m_cyc % DIV == 0) return 8'hFF;
      d    = cur_digit();
      code = m_disp[d*5 +: 5];
      off  = (((m_cyc / SCAN) / BF) % 2) == 1;
      if (code >= 5'd26 || (off && be_prev[d])) return 8'hFF;
      return dec(code);
   endfunction

   task automatic wait_ready(input string name);
      for (int k = 0; k < 200 && !m_ready; k++) @(negedge CLK);
      checks++;
      if (!m_ready) begin
         errors++;
         $display("FAIL %s: model never became ready within 200 cycles", name);
      end
   endtask

   task automatic test_reset();
      LOAD = 1'b0; LETTERS = '0; BLINK_EN = 4'h0;
      RST = 1'b0;
      #1 RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if ({an, seg, READY, LET} !== {4'hF, 8'hFF, 1'b1, 5'h1F}) begin
         errors++;
         $display("FAIL reset_state: an=%h seg=%h ready=%b let=%h, want F FF 1 1F", an, seg, READY, LET);
      end
      RST = 1'b0;
      repeat (4 * SCAN) begin
         @(negedge CLK);
         checks++;
         if ({an, seg, READY, LET} !== {exp_an(), exp_seg(), m_ready, exp_let()}) begin
            errors++;
            $display("FAIL idle_scan cyc=%0d: an=%h seg=%h ready=%b let=%h, want %h %h %b %h",
                     m_cyc, an, seg, READY, LET, exp_an(), exp_seg(), m_ready, exp_let());
         end
         BLINK_EN = 4'($urandom);
      end
   endtask

   task automatic test_load();
      BLINK_EN = 4'h0;
      wait_ready("load_wait");
      while ((m_cyc % SCAN) == SCAN - 1) @(negedge CLK);
      LOAD = 1'b1; LETTERS = {5'd0, 5'd1, 5'd2, 5'd3};
      @(negedge CLK);
      LOAD = 1'b0;
      checks++;
      if (READY !== 1'b0) begin
         errors++;
         $display("FAIL load_ready_drop: ready=%b, want 0", READY);
      end
      repeat (3 * SCAN) begin
         @(negedge CLK);
         checks++;
         if ({an, seg, READY, LET} !== {exp_an(), exp_seg(), m_ready, exp_let()}) begin
            errors++;
            $display("FAIL load_scan cyc=%0d: an=%h seg=%h ready=%b let=%h, want %h %h %b %h",
                     m_cyc, an, seg, READY, LET, exp_an(), exp_seg(), m_ready, exp_let());
         end
      end
   endtask

   task automatic test_ignore();
      wait_ready("ignore_wait");
      LOAD = 1'b1; LETTERS = {5'd3, 5'd2, 5'd1, 5'd0};
      @(negedge CLK);
      repeat (2 * SCAN) begin
         LOAD = ($urandom_range(0, 1) == 1); LETTERS = 20'($urandom);
         @(negedge CLK);
         checks++;
         if ({an, seg, READY, LET} !== {exp_an(), exp_seg(), m_ready, exp_let()}) begin
            errors++;
            $display("FAIL ignore_scan cyc=%0d: an=%h seg=%h ready=%b let=%h, want %h %h %b %h",
                     m_cyc, an, seg, READY, LET, exp_an(), exp_seg(), m_ready, exp_let());
         end
         if (m_ready) LOAD = 1'b0;
      end
      LOAD = 1'b0;
      wait_ready("wrap_wait");
      while ((m_cyc % SCAN) != SCAN - 1) @(negedge CLK);
      LOAD = 1'b1; LETTERS = {5'd4, 5'd5, 5'd6, 5'd7};
      @(negedge CLK);
      LOAD = 1'b0;
      checks++;
      if ({READY, LET} !== {1'b0, exp_let()}) begin
         errors++;
         $display("FAIL wrap_accept: ready=%b let=%h, want 0 %h", READY, LET, exp_let());
      end
      repeat (3 * SCAN) begin
         @(negedge CLK);
         checks++;
         if ({an, seg, READY, LET} !== {exp_an(), exp_seg(), m_ready, exp_let()}) begin
            errors++;
            $display("FAIL wrap_scan cyc=%0d: an=%h seg=%h ready=%b let=%h, want %h %h %b %h",
                     m_cyc, an, seg, READY, LET, exp_an(), exp_seg(), m_ready, exp_let());
         end
      end
   endtask

   task automatic test_frame(input string name, input logic [19:0] frame, input logic [3:0] be,
                             input int scans);
      wait_ready(name);
      LOAD = 1'b1; LETTERS = frame; BLINK_EN = be;
      @(negedge CLK);
      LOAD = 1'b0;
      repeat (scans * SCAN) begin
         @(negedge CLK);
         checks++;
         if ({an, seg, READY, LET} !== {exp_an(), exp_seg(), m_ready, exp_let()}) begin
            errors++;
            $display("FAIL %s cyc=%0d: an=%h seg=%h ready=%b let=%h, want %h %h %b %h",
                     name, m_cyc, an, seg, READY, LET, exp_an(), exp_seg(), m_ready, exp_let());
         end
      end
   endtask

   task automatic test_random();
      repeat (800) begin
         LOAD    = ($urandom_range(0, 3) == 0);
         LETTERS = 20'($urandom);
         if ($urandom_range(0, 7) == 0) BLINK_EN = 4'($urandom);
         @(negedge CLK);
         checks++;
         if ({an, seg, READY, LET} !== {exp_an(), exp_seg(), m_ready, exp_let()}) begin
            errors++;
            $display("FAIL random cyc=%0d: an=%h seg=%h ready=%b let=%h, want %h %h %b %h",
                     m_cyc, an, seg, READY, LET, exp_an(), exp_seg(), m_ready, exp_let());
         end
      end
      LOAD = 1'b0;
   endtask

   task automatic test_async_reset();
      BLINK_EN = 4'h0;
      wait_ready("areset_wait");
      LOAD = 1'b1; LETTERS = {5'd9, 5'd8, 5'd7, 5'd6};
      @(negedge CLK);
      LOAD = 1'b0;
      for (int k = 0; k < 50 && (m_cyc % DIV) != 2; k++) @(negedge CLK);
      checks++;
      if (m_ready || (m_cyc % DIV) != 2) begin
         errors++;
         $display("FAIL areset_setup: ready=%b slot_pos=%0d, want 0 2", m_ready, m_cyc % DIV);
      end
      #2 RST = 1'b1;
      #1;
      checks++;
      if ({an, seg, READY, LET} !== {4'hF, 8'hFF, 1'b1, 5'h1F}) begin
         errors++;
         $display("FAIL areset_now: an=%h seg=%h ready=%b let=%h, want F FF 1 1F", an, seg, READY, LET);
      end
      @(negedge CLK);
      RST = 1'b0;
      repeat (2 * SCAN) begin
         @(negedge CLK);
         checks++;
         if ({an, seg, READY, LET} !== {exp_an(), 8'hFF, 1'b1, 5'h1F}) begin
            errors++;
            $display("FAIL areset_after cyc=%0d: an=%h seg=%h ready=%b let=%h, want %h FF 1 1F",
                     m_cyc, an, seg, READY, LET, exp_an());
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_ignore();
      test_frame("blink", {5'd0, 5'd1, 5'd2, 5'd3}, 4'b0100, 10);
      test_frame("blank_code", {5'd27, 5'd0, 5'd0, 5'd0}, 4'b0000, 3);
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
